lab_5_divider: RTL

LAB_5_DIVIDER -- requirements
Module: lab_5_divider

---
 rtl/lab_5_divider.sv | 122 ++++++++++++
 1 files changed

// File: rtl/lab_5_divider.sv
// ----------------------------------------------------------------------------
// lab_5_divider : 8-bit unsigned restoring divider, one quotient bit per cycle
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lab_5_divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic       Busy,
  output logic       Done,
  output logic       DivZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dividend_q, dividend_d;
  logic [7:0]  divisor_q, divisor_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic [2:0]  step_q, step_d;
  logic        divzero_q, divzero_d;
  logic [8:0]  rem_shift;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      dividend_q <= 8'd0;
      divisor_q  <= 8'd0;
      quot_q     <= 8'd0;
      rem_q      <= 8'd0;
      step_q     <= 3'd0;
      divzero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      step_q     <= step_d;
      divzero_q  <= divzero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    step_d     = step_q;
    divzero_d  = divzero_q;
    rem_shift  = {rem_q, dividend_q[7]};

    case (state_q)
      IDLE: begin
        if (Run) begin
          dividend_d = A;
          divisor_d  = B;
          step_d     = 3'd0;
          if (B == 8'd0) begin
            quot_d    = 8'hFF;
            rem_d     = A;
            divzero_d = 1'b1;
            state_d   = DONE;
          end else begin
            quot_d    = 8'd0;
            rem_d     = 8'd0;
            divzero_d = 1'b0;
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        dividend_d = {dividend_q[6:0], 1'b0};
        // The difference is always below the divisor, so 8 bits hold it exactly.
        if (rem_shift >= {1'b0, divisor_q}) begin
          rem_d  = 8'(rem_shift - {1'b0, divisor_q});
          quot_d = {quot_q[6:0], 1'b1};
        end else begin
          rem_d  = rem_shift[7:0];
          quot_d = {quot_q[6:0], 1'b0};
        end
        step_d = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (!Run) begin
          divzero_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Q       = quot_q;
  assign R       = rem_q;
  assign Busy    = (state_q == CALC);
  assign Done    = (state_q == DONE);
  assign DivZero = divzero_q;

endmodule

`default_nettype wire
